// File: rtl/fifo_ms_pkg.sv
// Shared definitions for the multi-stream FIFO and its drain stage:
// output-buffer occupancy encoding and the tag-width helper.
package fifo_ms_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  // Width of a flow index; a single flow still needs one tag bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after ptr
// (mod FLUX) wins.
module rr_arbiter #(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      req,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic [FLUX-1:0]      grant,
  output logic [TAG_WIDTH-1:0] grant_idx,
  output logic                 any_grant
);

  always_comb begin
    grant     = {FLUX{1'b0}};
    grant_idx = {TAG_WIDTH{1'b0}};
    any_grant = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      int j;
      j = (int'(ptr) + i) % FLUX;
      if (!any_grant && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = TAG_WIDTH'(j);
        any_grant = 1'b1;
      end else begin
        any_grant = any_grant;
      end
    end
  end

endmodule

// File: rtl/fifo_ms_drain.sv
// Drains a multi-stream FIFO round-robin into a 2-entry in-order buffer
// feeding a valid/ready port, flagging words whose tag disagrees with the grant.
module fifo_ms_drain
  import fifo_ms_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FLUX       = 2,
  localparam int TAG_WIDTH  = tag_width(FLUX),
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLUX-1:0]       fifo_empty,
  output logic [FLUX-1:0]       fifo_read,
  input  logic [WIDTH-1:0]      fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  tag_err
);

  occ_e                  state_q;
  logic [TAG_WIDTH-1:0]  rr_q;
  logic [DATA_WIDTH-1:0] head_data_q, tail_data_q;
  logic [TAG_WIDTH-1:0]  head_tag_q, tail_tag_q;
  logic                  m_valid_q, tag_err_q;

  logic [FLUX-1:0]       req_s, gnt_s;
  logic [TAG_WIDTH-1:0]  gnt_idx_s, rr_d;
  logic                  any_s, push_s, pop_s;

  assign req_s = ~fifo_empty;

  rr_arbiter #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_arb (
    .req       (req_s),
    .ptr       (rr_q),
    .grant     (gnt_s),
    .grant_idx (gnt_idx_s),
    .any_grant (any_s)
  );

  // Pop only while the buffer has room; rst gates the strobe combinationally.
  always_comb begin
    push_s    = !rst && any_s && (state_q != ST_TWO);
    pop_s     = m_valid_q && m_ready;
    fifo_read = push_s ? gnt_s : {FLUX{1'b0}};
    if (gnt_idx_s == TAG_WIDTH'(FLUX - 1)) begin
      rr_d = {TAG_WIDTH{1'b0}};
    end else begin
      rr_d = gnt_idx_s + {{(TAG_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      rr_q        <= {TAG_WIDTH{1'b0}};
      head_data_q <= {DATA_WIDTH{1'b0}};
      tail_data_q <= {DATA_WIDTH{1'b0}};
      head_tag_q  <= {TAG_WIDTH{1'b0}};
      tail_tag_q  <= {TAG_WIDTH{1'b0}};
      m_valid_q   <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      if (push_s) begin
        rr_q <= rr_d;
        if (fifo_dout[WIDTH-1:DATA_WIDTH] != gnt_idx_s) begin
          tag_err_q <= 1'b1;
        end
      end
      // m_tag carries the granted index, never the received tag bits.
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            head_data_q <= fifo_dout[DATA_WIDTH-1:0];
            head_tag_q  <= gnt_idx_s;
            state_q     <= ST_ONE;
            m_valid_q   <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_data_q <= fifo_dout[DATA_WIDTH-1:0];
            head_tag_q  <= gnt_idx_s;
          end else if (push_s) begin
            tail_data_q <= fifo_dout[DATA_WIDTH-1:0];
            tail_tag_q  <= gnt_idx_s;
            state_q     <= ST_TWO;
          end else if (pop_s) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            head_data_q <= tail_data_q;
            head_tag_q  <= tail_tag_q;
            state_q     <= ST_ONE;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = head_data_q;
  assign m_tag   = head_tag_q;
  assign tag_err = tag_err_q;

endmodule

// File: doc/fifo_ms_drain.md
FIFO_MS_DRAIN -- requirements
Module: fifo_ms_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width per word.
REQ-002 SHALL have parameter FLUX, default 2, number of flows (>=2).
REQ-003 SHALL derive TAG_WIDTH = $clog2(FLUX) and WIDTH = DATA_WIDTH+TAG_WIDTH; these are not overridable.
REQ-004 SHALL use clock clk and reset rst, synchronous, active-high.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 fifo_empty  input  FLUX  per-flow empty flags from multi-stream FIFO read side.
REQ-008 fifo_read  output  FLUX  one-hot-or-zero pop strobe to the FIFO.
REQ-009 fifo_dout  input  WIDTH  {tag, data} word of flow selected by fifo_read, valid same cycle as fifo_read.
REQ-010 m_valid  output  1  downstream word available.
REQ-011 m_ready  input  1  downstream accepts word.
REQ-012 m_data  output  DATA_WIDTH  downstream payload.
REQ-013 m_tag  output  TAG_WIDTH  flow index of m_data.
REQ-014 tag_err  output  1  sticky tag mismatch flag.

Function
REQ-015 SHALL hold a 2-entry in-order output buffer with states EMPTY, ONE, TWO (occupancy 0/1/2).
REQ-016 SHALL assert fifo_read only when buffer state is EMPTY or ONE and at least one fifo_empty bit is 0; never when TWO, regardless of m_ready.
REQ-017 fifo_read SHALL have at most one bit set, selecting the granted flow.
REQ-018 Grant SHALL be round-robin: search starts at priority pointer rr; first non-empty flow at or after rr (mod FLUX) wins; after a grant to k, rr <= (k+1) mod FLUX; rr unchanged when no grant.
REQ-019 On a grant, fifo_dout[DATA_WIDTH-1:0] and granted index SHALL be written into the buffer at the same clock edge; word appears on m_valid/m_data/m_tag next cycle (1-cycle latency) when buffer was EMPTY.
REQ-020 m_tag SHALL carry the granted index, not the received tag bits.
REQ-021 If fifo_dout[WIDTH-1:DATA_WIDTH] != granted index on a grant, tag_err SHALL set next cycle and stay set until reset; the word is still forwarded.
REQ-022 m_valid SHALL equal (state != EMPTY); m_data/m_tag SHALL present the head entry and remain stable while m_valid && !m_ready.
REQ-023 Pop occurs when m_valid && m_ready; simultaneous push and pop SHALL keep occupancy (ONE->ONE, TWO->ONE-with-push impossible since no push in TWO).
REQ-024 Transitions: EMPTY->ONE on push; ONE->TWO on push w/o pop; ONE->EMPTY on pop w/o push; ONE->ONE on push+pop; TWO->ONE on pop; otherwise hold.
REQ-025 Throughput SHALL be one word per cycle sustained when m_ready stays 1 and any flow non-empty.
REQ-026 All-flows-empty SHALL produce fifo_read = 0 and no state change other than pops.

Reset
REQ-027 While rst is 1, fifo_read SHALL be forced to 0 combinationally.
REQ-028 Reset SHALL set state EMPTY, m_valid 0, m_data 0, m_tag 0, tag_err 0, rr 0, buffer entries 0.
REQ-029 Reset mid-transfer SHALL discard buffered words; no pop issued in the reset cycle.

Structure
REQ-030 Shared package fifo_ms_pkg SHALL hold the occupancy state enum and a tag-width helper function used by fifo_ms and fifo_ms_drain.
REQ-031 The round-robin selector SHALL be a sub-module rr_arbiter (inputs req[FLUX], ptr; outputs one-hot grant, grant index, any_grant).

Verification
REQ-032 FLUX=2, flow0 holds 0xA1,0xA2, flow1 holds 0xB1,0xB2, m_ready=1 -> m_data sequence A1,B1,A2,B2 with m_tag 0,1,0,1, back-to-back cycles.
REQ-033 Flow1 only non-empty, rr=0 -> fifo_read=2'b10 each cycle, m_tag=1 throughout, rr becomes 0 after each grant.
REQ-034 m_ready=0 with flows non-empty -> exactly two reads issued, state TWO, fifo_read=0 afterwards, m_data holds first word stable; m_ready=1 -> draining resumes, no word lost/duplicated.
REQ-035 Grant to flow0 while fifo_dout tag=1 -> tag_err=1 next cycle and stays 1; word forwarded with m_tag=0.
REQ-036 rst asserted while state TWO -> same cycle fifo_read=0, next cycle m_valid=0, tag_err=0, next grant starts from flow0.
REQ-037 All fifo_empty=1 for 10 cycles -> fifo_read=0, m_valid stays 0, rr unchanged.
